thread_pc_scheduler: RTL

Per-thread program-counter store and round-robin thread issuer for the barrel core's fetch stage. Holds one PC per hardware thread and selects one thread per cycle in round-robin order, skipping inactive threads. Presents that thread's PC, PC+4 and thread id to instruction fetch. Accepts branch/jump redirects from the execute stage (`pc_src_e`, `pc_target_e`, `tid_e`) and applies each one to the thread that resolved it.

---
 rtl/barrel_pkg.sv | 9 +
 rtl/rr_next_thread.sv | 19 +
 rtl/thread_pc_scheduler.sv | 50 +++++
 3 files changed

// File: rtl/barrel_pkg.sv
// barrel_pkg: shared thread-count, reset-PC defaults and id/address types for the barrel core
package barrel_pkg;
    localparam int ADDRESS_WIDTH = 32;
    localparam int NUM_THREADS = 8;
    localparam int BITS_THREADS = $clog2(NUM_THREADS);
    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'h0000_0000;
    typedef logic [BITS_THREADS-1:0] tid_t;
    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
endpackage

// File: rtl/rr_next_thread.sv
// rr_next_thread: round-robin search for the next active thread after cur_tid, cur_tid itself last
module rr_next_thread #(
    parameter int NUM_THREADS = barrel_pkg::NUM_THREADS,
    parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic [BITS_THREADS-1:0] cur_tid,
    input  logic [NUM_THREADS-1:0]  thread_active,
    output logic [BITS_THREADS-1:0] next_tid,
    output logic                    any_active
);
    assign any_active = |thread_active;
    // Scan farthest-first so the nearest active successor is the final assignment.
    always_comb begin
        next_tid = cur_tid;
        for (int i = NUM_THREADS; i >= 1; i--)
            if (thread_active[BITS_THREADS'(cur_tid + BITS_THREADS'(i))])
                next_tid = BITS_THREADS'(cur_tid + BITS_THREADS'(i));
    end
endmodule

// File: rtl/thread_pc_scheduler.sv
// thread_pc_scheduler: per-thread PC store with round-robin issue and execute-stage redirects
module thread_pc_scheduler #(
    parameter int ADDRESS_WIDTH = barrel_pkg::ADDRESS_WIDTH,
    parameter int NUM_THREADS = barrel_pkg::NUM_THREADS,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(barrel_pkg::RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_THREADS-1:0]   thread_active,
    input  logic                     stall_f,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    output logic [BITS_THREADS-1:0]  tid_f,
    output logic                     valid_f
);
    logic [ADDRESS_WIDTH-1:0] pc [NUM_THREADS];
    logic [BITS_THREADS-1:0] cur_tid, next_tid;
    logic any_active;

    rr_next_thread #(.NUM_THREADS(NUM_THREADS), .BITS_THREADS(BITS_THREADS)) u_rr (
        .cur_tid(cur_tid),
        .thread_active(thread_active),
        .next_tid(next_tid),
        .any_active(any_active)
    );

    assign tid_f = cur_tid;
    assign pc_f = pc[cur_tid];
    assign pc_plus4_f = pc_f + ADDRESS_WIDTH'(4);
    assign valid_f = thread_active[cur_tid] & ~stall_f;

    // Redirect takes priority over the issue increment on the same thread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++)
                pc[t] <= RESET_PC;
            cur_tid <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++)
                pc[t] <= (pc_src_e && tid_e == BITS_THREADS'(t)) ? pc_target_e :
                         (valid_f && cur_tid == BITS_THREADS'(t)) ? pc_plus4_f : pc[t];
            if (!stall_f && any_active)
                cur_tid <= next_tid;
        end
    end
endmodule
